// File: rtl/ama_riscv_perf_pkg.sv
// Shared constants for the ama_riscv performance-counter unit: register map, CTRL bits, counter indices.
package ama_riscv_perf_pkg;

  localparam int ADDR_CTRL       = 0;
  localparam int ADDR_OVF        = 1;
  localparam int ADDR_CYC_LO     = 2;
  localparam int ADDR_INSTRET_LO = 4;
  localparam int ADDR_EVT_BASE   = 6;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_FRZ = 1;
  localparam int CTRL_CLR = 2;

  typedef enum logic [3:0] {
    CNT_CYCLE   = 4'd0,
    CNT_INSTRET = 4'd1,
    CNT_EVT0    = 4'd2,
    CNT_EVT1    = 4'd3,
    CNT_EVT2    = 4'd4,
    CNT_EVT3    = 4'd5,
    CNT_EVT4    = 4'd6,
    CNT_EVT5    = 4'd7,
    CNT_EVT6    = 4'd8,
    CNT_EVT7    = 4'd9
  } cnt_idx_e;

  // Counters sit in lo/hi pairs starting at the cycle counter, so index maps linearly to address.
  function automatic int cnt_lo_addr(input int idx);
    return ADDR_CYC_LO + 2 * idx;
  endfunction

endpackage

// File: rtl/ama_riscv_perf_ctr.sv
// One CNT_W-bit performance counter with clear, per-half preload and wrap detection.
// Priority clr > preload > inc; ovf_set is a combinational pulse in the cycle the wrap is taken.
module ama_riscv_perf_ctr
  import ama_riscv_perf_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             ld_lo,
  input  logic             ld_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] value,
  output logic             ovf_set
);

  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld_lo) begin
      cnt[31:0] <= wdata;
    end else if (ld_hi) begin
      cnt[CNT_W-1:32] <= wdata[HI_W-1:0];
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign value   = cnt;
  assign ovf_set = inc && !clr && !ld_lo && !ld_hi && (&cnt);

endmodule

// File: rtl/ama_riscv_perf_cnt.sv
// Cycle, instret and NUM_EVT event counters behind a word-addressed MMIO port.
// Reads answer one cycle later with no backpressure; lo reads latch the hi half into a shared shadow.
module ama_riscv_perf_cnt
  import ama_riscv_perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 64,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inst_retired,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               mmio_reset_cnt,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata
);

  localparam int NCNT = int'(CNT_EVT0) + NUM_EVT;
  localparam int HI_W = CNT_W - 32;

  logic             en, frz, active;
  logic             wr, rd, clr_all, ctrl_sel, ovf_sel;
  logic [NCNT-1:0]  inc_vec, ovf_set, ovf, ovf_w1c;
  logic [CNT_W-1:0] cnt_val [NCNT];
  logic [HI_W-1:0]  shadow, shadow_nxt;
  logic [31:0]      rd_data;

  assign wr       = req_valid && req_we;
  assign rd       = req_valid && !req_we;
  assign ctrl_sel = (req_addr == ADDR_W'(ADDR_CTRL));
  assign ovf_sel  = (req_addr == ADDR_W'(ADDR_OVF));
  assign active   = en && !frz;
  assign clr_all  = mmio_reset_cnt || (wr && ctrl_sel && req_wdata[CTRL_CLR]);
  assign inc_vec  = {evt & {NUM_EVT{active}}, active && inst_retired, active};
  assign ovf_w1c  = (wr && ovf_sel) ? req_wdata[NCNT-1:0] : '0;

  for (genvar i = 0; i < NCNT; i++) begin : g_ctr
    localparam logic [ADDR_W-1:0] LO_A = ADDR_W'(cnt_lo_addr(i));
    localparam logic [ADDR_W-1:0] HI_A = ADDR_W'(cnt_lo_addr(i) + 1);

    ama_riscv_perf_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc_vec[i]),
      .clr     (clr_all),
      .ld_lo   (wr && (req_addr == LO_A)),
      .ld_hi   (wr && (req_addr == HI_A)),
      .wdata   (req_wdata),
      .value   (cnt_val[i]),
      .ovf_set (ovf_set[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= 1'b1;
      frz <= 1'b0;
    end else if (wr && ctrl_sel) begin
      en  <= req_wdata[CTRL_EN];
      frz <= req_wdata[CTRL_FRZ];
    end
  end

  // A wrap in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else if (clr_all) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~ovf_w1c) | ovf_set;
    end
  end

  always_comb begin
    rd_data    = '0;
    shadow_nxt = shadow;
    if (ctrl_sel) begin
      rd_data = 32'({frz, en});
    end else if (ovf_sel) begin
      rd_data = 32'(ovf);
    end
    for (int i = 0; i < NCNT; i++) begin
      if (req_addr == ADDR_W'(cnt_lo_addr(i))) begin
        rd_data    = cnt_val[i][31:0];
        shadow_nxt = cnt_val[i][CNT_W-1:32];
      end
      if (req_addr == ADDR_W'(cnt_lo_addr(i) + 1)) begin
        rd_data = 32'(shadow);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rd;
      if (rd) begin
        shadow    <= shadow_nxt;
        rsp_rdata <= rd_data;
      end
    end
  end

endmodule
